// File: rtl/vbh_pkg.sv
// Shared constants for the Game Boy to DSI pixel path: geometry, palette and
// the pixel feeder's FSM encoding.
package vbh_pkg;

    localparam int SRC_W  = 160;
    localparam int SRC_H  = 144;
    localparam int OUT_W  = 320;
    localparam int OUT_H  = 320;
    localparam int V_OFS  = 16;

    localparam int CNT_W  = 9;
    localparam int ADDR_W = 15;
    localparam int RGB_W  = 24;

    localparam logic [RGB_W-1:0] BORDER_RGB = 24'h000000;
    localparam logic [RGB_W-1:0] PAL0       = 24'hE0F8D0;
    localparam logic [RGB_W-1:0] PAL1       = 24'h88C070;
    localparam logic [RGB_W-1:0] PAL2       = 24'h346856;
    localparam logic [RGB_W-1:0] PAL3       = 24'h081820;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } pix_state_t;

endpackage

// File: rtl/dsi_pix_palette.sv
// Maps a 2-bit Game Boy shade to RGB888; border pixels override the shade.
module dsi_pix_palette
    import vbh_pkg::*;
(
    input  logic [1:0]       shade,
    input  logic             border,
    output logic [RGB_W-1:0] rgb
);

    always_comb begin
        rgb = BORDER_RGB;
        if (!border) begin
            case (shade)
                2'd0:    rgb = PAL0;
                2'd1:    rgb = PAL1;
                2'd2:    rgb = PAL2;
                default: rgb = PAL3;
            endcase
        end
    end

endmodule

// File: rtl/dsi_pix_feeder.sv
// Streams the 2x-scaled, border-padded framebuffer to dsi_core, one frame
// per rising edge of pix_next_frame_i.
module dsi_pix_feeder #(
    parameter int SRC_W = vbh_pkg::SRC_W,
    parameter int SRC_H = vbh_pkg::SRC_H,
    parameter int OUT_W = vbh_pkg::OUT_W,
    parameter int OUT_H = vbh_pkg::OUT_H,
    parameter int V_OFS = vbh_pkg::V_OFS
) (
    input  logic                       clk_dsi,
    input  logic                       rst,
    output logic [vbh_pkg::ADDR_W-1:0] fb_addr_o,
    output logic                       fb_rd_o,
    input  logic [1:0]                 fb_data_i,
    input  logic                       pix_next_frame_i,
    input  logic                       pix_almost_full_i,
    output logic [vbh_pkg::RGB_W-1:0]  pix_o,
    output logic                       pix_wr_o,
    output logic                       busy_o,
    output logic                       overrun_o,
    output logic [1:0]                 state_dbg_o
);
    import vbh_pkg::*;

    localparam logic [CNT_W-1:0]  X_LAST    = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0]  Y_LAST    = CNT_W'(OUT_H - 1);
    localparam logic [CNT_W-1:0]  Y_TOP     = CNT_W'(V_OFS);
    localparam logic [CNT_W-1:0]  Y_BOT     = CNT_W'(V_OFS + 2 * SRC_H);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(SRC_W);

    pix_state_t        state;
    logic [CNT_W-1:0]  x, y;
    logic [ADDR_W-1:0] line_base;
    logic              odd_line;
    logic              last_nf, armed;
    logic              s0_valid, s0_border, s1_valid, s1_border;
    logic              req, issue, border;
    logic [RGB_W-1:0]  pal_rgb;

    // Handshake: pix_wr_o is a valid-only strobe with no ready; a high
    // pix_almost_full_i stops new issues that same cycle, while the <=2
    // pixels already in the pipeline still complete.
    // armed stays low after reset until the request level has been seen low,
    // so a level held through reset does not start a frame.
    assign req    = pix_next_frame_i & ~last_nf & armed;
    assign issue  = (state == ACTIVE) & ~pix_almost_full_i;
    assign border = (y < Y_TOP) | (y >= Y_BOT);

    assign state_dbg_o = state;

    dsi_pix_palette u_palette (
        .shade  (fb_data_i),
        .border (s1_border),
        .rgb    (pal_rgb)
    );

    always_ff @(posedge clk_dsi) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            odd_line  <= 1'b0;
            last_nf   <= 1'b0;
            armed     <= 1'b0;
            s0_valid  <= 1'b0;
            s0_border <= 1'b0;
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
            fb_addr_o <= '0;
            fb_rd_o   <= 1'b0;
            pix_o     <= '0;
            pix_wr_o  <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            last_nf <= pix_next_frame_i;
            if (!pix_next_frame_i) armed <= 1'b1;

            s0_valid  <= issue;
            s0_border <= border;
            s1_valid  <= s0_valid;
            s1_border <= s0_border;
            pix_wr_o  <= s1_valid;
            if (s1_valid) pix_o <= pal_rgb;

            fb_rd_o <= issue & ~border;
            if (issue && !border) fb_addr_o <= line_base + ADDR_W'(x[CNT_W-1:1]);

            if (req && state != IDLE) overrun_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        line_base <= '0;
                        odd_line  <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (issue) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                            // Each source line feeds two output lines.
                            if (!border) begin
                                odd_line <= ~odd_line;
                                if (odd_line) line_base <= line_base + BASE_STEP;
                            end
                            if (y == Y_LAST) state <= DRAIN;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!s0_valid && !s1_valid) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_pix_feeder.sv
// Directed bench for dsi_pix_feeder on a reduced frame geometry, with a
// 1-cycle framebuffer model and an in-order pixel/address scoreboard.
module tb_dsi_pix_feeder;

    localparam int SRC_W = 6;
    localparam int SRC_H = 4;
    localparam int OUT_W = 12;
    localparam int OUT_H = 12;
    localparam int V_OFS = 2;
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int NRD   = OUT_W * 2 * SRC_H;
    localparam int LIMIT = 4000;

    logic        clk_dsi = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] fb_addr_o;
    logic        fb_rd_o;
    logic [1:0]  fb_data_i = 2'd0;
    logic        pix_next_frame_i = 1'b0;
    logic        pix_almost_full_i = 1'b0;
    logic [23:0] pix_o;
    logic        pix_wr_o;
    logic        busy_o;
    logic        overrun_o;
    logic [1:0]  state_dbg_o;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    logic [14:0] exp_addr_q[$];

    int cyc = 0;
    int wr_count = 0, rd_count = 0;
    int first_rd_cyc = 0, first_rd_addr = 0, last_rd_addr = 0;
    int first_wr_cyc = 0, last_wr_cyc = 0, first_act_wr_cyc = 0;
    int busy_low_cyc = 0;
    int fb_mode = 0;
    logic af_at_edge = 1'b0;

    dsi_pix_feeder #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .OUT_W(OUT_W), .OUT_H(OUT_H), .V_OFS(V_OFS)
    ) dut (
        .clk_dsi           (clk_dsi),
        .rst               (rst),
        .fb_addr_o         (fb_addr_o),
        .fb_rd_o           (fb_rd_o),
        .fb_data_i         (fb_data_i),
        .pix_next_frame_i  (pix_next_frame_i),
        .pix_almost_full_i (pix_almost_full_i),
        .pix_o             (pix_o),
        .pix_wr_o          (pix_wr_o),
        .busy_o            (busy_o),
        .overrun_o         (overrun_o),
        .state_dbg_o       (state_dbg_o)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk_dsi = ~clk_dsi;

    task automatic tick();
        @(posedge clk_dsi);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- framebuffer and reference model ----------------
    function automatic logic [1:0] shade_of(input logic [14:0] a);
        logic [14:0] h;
        h = a ^ (a >> 2) ^ (a >> 3);
        return (fb_mode == 0) ? a[1:0] : h[1:0];
    endfunction

    function automatic logic [23:0] pal(input logic [1:0] s);
        case (s)
            2'd0:    return 24'hE0F8D0;
            2'd1:    return 24'h88C070;
            2'd2:    return 24'h346856;
            default: return 24'h081820;
        endcase
    endfunction

    task automatic push_expect();
        int a;
        for (int oy = 0; oy < OUT_H; oy++) begin
            for (int ox = 0; ox < OUT_W; ox++) begin
                if (oy < V_OFS || oy >= V_OFS + 2 * SRC_H) begin
                    exp_q.push_back(24'h000000);
                end else begin
                    a = ((oy - V_OFS) / 2) * SRC_W + ox / 2;
                    exp_q.push_back(pal(shade_of(15'(a))));
                    exp_addr_q.push_back(15'(a));
                end
            end
        end
    endtask

    always @(posedge clk_dsi) begin
        cyc        <= cyc + 1;
        af_at_edge <= pix_almost_full_i;
        if (fb_rd_o) fb_data_i <= shade_of(fb_addr_o);
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk_dsi) begin
        if (fb_rd_o) begin
            check("rd_while_af", 32'(af_at_edge), 32'd0);
            if (rd_count == 0) begin
                first_rd_cyc  = cyc;
                first_rd_addr = int'(fb_addr_o);
            end
            last_rd_addr = int'(fb_addr_o);
            rd_count++;
            if (exp_addr_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
            else check("rd_addr", 32'(fb_addr_o), 32'(exp_addr_q.pop_front()));
        end
        if (pix_wr_o) begin
            if (wr_count == 0) first_wr_cyc = cyc;
            if (wr_count == V_OFS * OUT_W) first_act_wr_cyc = cyc;
            last_wr_cyc = cyc;
            wr_count++;
            if (exp_q.size() == 0) check("pix_extra", 32'd1, 32'd0);
            else check("pix", 32'(pix_o), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_frame(input int af_pct, input bit mid_req);
        bit seen, done;
        int phase;
        push_expect();
        wr_count = 0;
        rd_count = 0;
        seen = 0;
        done = 0;
        phase = 0;
        pix_next_frame_i = 1'b0;
        tick();
        pix_next_frame_i = 1'b1;
        for (int i = 0; i < LIMIT && !done; i++) begin
            tick();
            pix_almost_full_i = ($urandom_range(0, 99) < af_pct);
            if (mid_req && phase == 0 && wr_count >= NPIX / 2) begin
                pix_next_frame_i = 1'b0;
                phase = 1;
            end else if (phase == 1) begin
                pix_next_frame_i = 1'b1;
                phase = 2;
            end
            if (busy_o) seen = 1;
            if (seen && !busy_o) begin
                done = 1;
                busy_low_cyc = cyc;
            end
        end
        pix_almost_full_i = 1'b0;
        check("frame_done", 32'(done), 32'd1);
        check("pix_count", 32'(wr_count), 32'(NPIX));
        check("exp_q_left", 32'(exp_q.size()), 32'd0);
        check("rd_count", 32'(rd_count), 32'(NRD));
        check("first_rd_addr", 32'(first_rd_addr), 32'd0);
        check("last_rd_addr", 32'(last_rd_addr), 32'(SRC_W * SRC_H - 1));
        check("busy_after_last", 32'(busy_low_cyc > last_wr_cyc), 32'd1);
        if (af_pct == 0) begin
            check("latency", 32'(first_act_wr_cyc - first_rd_cyc), 32'd2);
            check("back_to_back", 32'(last_wr_cyc - first_wr_cyc), 32'(NPIX - 1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_seen;

        repeat (3) tick();
        check("rst_fb_addr", 32'(fb_addr_o), 32'd0);
        check("rst_fb_rd", 32'(fb_rd_o), 32'd0);
        check("rst_pix", 32'(pix_o), 32'd0);
        check("rst_pix_wr", 32'(pix_wr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_state", 32'(state_dbg_o), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Unthrottled frame, shade = addr % 4.
        fb_mode = 0;
        run_frame(0, 0);
        check("no_overrun", 32'(overrun_o), 32'd0);

        // Throttled frame with a scrambled framebuffer.
        fb_mode = 1;
        run_frame(30, 0);

        // Extra request mid-frame, then a normal frame after it.
        fb_mode = 0;
        run_frame(0, 1);
        check("overrun_set", 32'(overrun_o), 32'd1);
        fb_mode = 1;
        run_frame(25, 0);
        check("overrun_sticky", 32'(overrun_o), 32'd1);

        // Reset in the middle of a frame.
        fb_mode = 0;
        push_expect();
        wr_count = 0;
        rd_count = 0;
        pix_next_frame_i = 1'b0;
        tick();
        pix_next_frame_i = 1'b1;
        for (int i = 0; i < LIMIT && wr_count < NPIX / 2; i++) tick();
        check("mid_reached", 32'(wr_count >= NPIX / 2), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_pix_wr", 32'(pix_wr_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_overrun", 32'(overrun_o), 32'd0);
        check("midrst_fb_rd", 32'(fb_rd_o), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        rst = 1'b0;
        pix_next_frame_i = 1'b0;
        repeat (2) tick();
        run_frame(0, 0);

        // Request level held high through reset release.
        pix_next_frame_i = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        rd_count = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_o) busy_seen++;
        end
        check("held_nf_busy", 32'(busy_seen), 32'd0);
        check("held_nf_rd", 32'(rd_count), 32'd0);
        fb_mode = 1;
        run_frame(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
